inst_sequencer: RTL and testbench

- Program sequencer between the input front end (switch/UART loader) and the lab2 calculator datapath (PUSH/ADD/MULT/SEND, 4 registers).
- Holds a small instruction buffer and issues instructions to the datapath one at a time over a valid/ready handshake. This replaces manual switch-and-button stepping.
- Throttles SEND instructions against the UART transmitter.
- Supports free-run and single-step modes.

---
 rtl/inst_sequencer.sv | 115 +++++++++++
 tb/tb_inst_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Program sequencer: buffers loader instructions and issues them one at a time to the
// calculator datapath, throttling SEND against the UART and supporting single-step.
module inst_sequencer #(
    parameter int AW = 4,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_vld,
    input  logic [IW-1:0] load_data,
    output logic          load_rdy,
    input  logic          clear,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          halt,
    output logic          inst_vld,
    output logic [IW-1:0] inst_wd,
    input  logic          inst_rdy,
    input  logic          send_busy,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, PAUSE, FINISH} state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [IW-1:0] mem [2**AW];
    logic          guard;
    logic          load_fire;
    logic          handshake;
    logic          is_send;
    logic          is_last;
    logic          advance;
    logic [AW-1:0] pc_inc;

    assign load_rdy  = (state == IDLE) && (count < DEPTH);
    assign load_fire = load_rdy && load_vld && !clear;
    assign inst_vld  = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign handshake = inst_vld && inst_rdy;
    assign is_send   = (inst_wd[IW-1 -: 2] == 2'b11);
    assign is_last   = ({1'b0, pc} == count - 1'b1);
    assign pc_inc    = pc + 1'b1;

    // Shared step decision for a non-SEND handshake and for leaving WAIT_TX.
    assign advance = (state == ISSUE && handshake && !is_send) ||
                     (state == WAIT_TX && !guard && !send_busy);

    always_ff @(posedge clk) begin
        if (load_fire)
            mem[count[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            pc      <= '0;
            inst_wd <= '0;
            guard   <= 1'b0;
        end else if (halt && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (clear)
                        count <= '0;
                    else if (load_fire)
                        count <= count + 1'b1;
                    if (start && !clear && count != '0) begin
                        pc      <= '0;
                        inst_wd <= mem[{AW{1'b0}}];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake && is_send) begin
                        guard <= 1'b1;
                        state <= WAIT_TX;
                    end
                end
                WAIT_TX: guard <= 1'b0;
                PAUSE: begin
                    if (step) begin
                        inst_wd <= mem[pc];
                        state   <= ISSUE;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (advance) begin
                if (is_last) begin
                    state <= FINISH;
                end else begin
                    pc <= pc_inc;
                    if (step_mode) begin
                        state <= PAUSE;
                    end else begin
                        inst_wd <= mem[pc_inc];
                        state   <= ISSUE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: stimulus queues expected issues, a negedge
// monitor pops and compares them on every valid/ready handshake.
module tb_inst_sequencer;
    localparam int AW = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_vld = 1'b0;
    logic [IW-1:0] load_data = '0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          halt = 1'b0;
    logic          inst_rdy = 1'b0;
    logic          send_busy = 1'b0;
    logic          load_rdy, inst_vld, busy, done;
    logic [IW-1:0] inst_wd;
    logic [AW-1:0] pc;
    logic [AW:0]   count;

    typedef struct packed {
        logic [7:0] wd;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    inst_sequencer #(.AW(AW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_vld(load_vld), .load_data(load_data), .load_rdy(load_rdy),
        .clear(clear), .start(start), .step_mode(step_mode), .step(step), .halt(halt),
        .inst_vld(inst_vld), .inst_wd(inst_wd), .inst_rdy(inst_rdy),
        .send_busy(send_busy), .busy(busy), .done(done), .pc(pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] wd, input logic [3:0] p);
        exp_t e;
        e.wd = wd;
        e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic load_word(input logic [7:0] w);
        check("load_rdy", {31'b0, load_rdy}, 1);
        load_vld  = 1'b1;
        load_data = w;
        tick();
        load_vld  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_pulse", {31'b0, seen}, 1);
        tick();
        check("busy_after_done", {31'b0, busy}, 0);
    endtask

    task automatic check_reset_state();
        check("rst_count", {27'b0, count}, 0);
        check("rst_pc", {28'b0, pc}, 0);
        check("rst_vld", {31'b0, inst_vld}, 0);
        check("rst_wd", {24'b0, inst_wd}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
    endtask

    // Monitor: a handshake is seen at the negedge before the accepting edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && inst_vld && inst_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got wd=%0h pc=%0d expected none", inst_wd, pc);
            end else begin
                e = exp_q.pop_front();
                check("issue_wd", {24'b0, inst_wd}, {24'b0, e.wd});
                check("issue_pc", {28'b0, pc}, {28'b0, e.pc});
            end
        end
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] prog1 [4];
        prog1 = '{8'h04, 8'h13, 8'h86, 8'hE0};

        // Reset and basic free-run with a throttled SEND
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_state();
        check("rst_load_rdy", {31'b0, load_rdy}, 1);
        for (int i = 0; i < 4; i++) load_word(prog1[i]);
        check("count4", {27'b0, count}, 4);
        for (int i = 0; i < 4; i++) push(prog1[i], 4'(i));
        inst_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_vld", {31'b0, inst_vld}, 1);
            check("b2b_wd", {24'b0, inst_wd}, {24'b0, prog1[i]});
            tick();
        end
        send_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("wait_vld", {31'b0, inst_vld}, 0);
            check("wait_nodone", {31'b0, done}, 0);
            tick();
        end
        send_busy = 1'b0;
        check("wait_still_busy", {31'b0, busy}, 1);
        check("wait_nodone_last", {31'b0, done}, 0);
        tick();
        check("done_after_tx", {31'b0, done}, 1);
        tick();
        check("done_one_cycle", {31'b0, done}, 0);
        check("idle_after_run1", {31'b0, busy}, 0);
        check("done_cnt1", done_cnt, 1);
        check("q_empty1", exp_q.size(), 0);

        // Stall on entry 1
        for (int i = 0; i < 4; i++) push(prog1[i], 4'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_first_wd", {24'b0, inst_wd}, 32'h04);
        tick();
        inst_rdy = 1'b0;
        check("stall_pc_entry", {28'b0, pc}, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("stall_vld", {31'b0, inst_vld}, 1);
            check("stall_wd", {24'b0, inst_wd}, 32'h13);
            check("stall_pc", {28'b0, pc}, 1);
        end
        inst_rdy = 1'b1;
        wait_done(30);
        check("done_cnt2", done_cnt, 2);
        check("q_empty2", exp_q.size(), 0);

        // Fill to 16 with a 17th word refused, then run to pc=15
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", {27'b0, count}, 0);
        load_vld = 1'b1;
        for (int i = 0; i < 17; i++) begin
            load_data = 8'(8'h20 + i);
            check("fill_load_rdy", {31'b0, load_rdy}, (i < 16) ? 32'd1 : 32'd0);
            tick();
        end
        load_vld = 1'b0;
        check("full_count", {27'b0, count}, 16);
        check("full_load_rdy", {31'b0, load_rdy}, 0);
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 4'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        check("full_pc_end", {28'b0, pc}, 15);
        check("done_cnt3", done_cnt, 3);
        check("q_empty3", exp_q.size(), 0);

        // Single-step mode
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_word(8'h05);
        load_word(8'h4A);
        load_word(8'h91);
        step_mode = 1'b1;
        push(8'h05, 4'd0);
        push(8'h4A, 4'd1);
        push(8'h91, 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        check("pause1_vld", {31'b0, inst_vld}, 0);
        check("pause1_pc", {28'b0, pc}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause1_hold", {31'b0, inst_vld}, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step1_vld", {31'b0, inst_vld}, 1);
        check("step1_wd", {24'b0, inst_wd}, 32'h4A);
        tick();
        check("pause2_vld", {31'b0, inst_vld}, 0);
        check("pause2_pc", {28'b0, pc}, 2);
        tick();
        check("pause2_hold", {31'b0, inst_vld}, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step2_wd", {24'b0, inst_wd}, 32'h91);
        tick();
        check("step_done", {31'b0, done}, 1);
        tick();
        check("step_idle", {31'b0, busy}, 0);
        step_mode = 1'b0;
        check("done_cnt4", done_cnt, 4);

        // Halt while waiting on the UART, then re-run
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_word(8'h04);
        load_word(8'hE0);
        load_word(8'h13);
        push(8'h04, 4'd0);
        push(8'hE0, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("halt_in_wait", {31'b0, inst_vld}, 0);
        send_busy = 1'b1;
        tick();
        tick();
        check("halt_pre_busy", {31'b0, busy}, 1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_busy", {31'b0, busy}, 0);
        check("halt_vld", {31'b0, inst_vld}, 0);
        check("halt_count", {27'b0, count}, 3);
        tick();
        tick();
        check("halt_no_done", done_cnt, 4);
        send_busy = 1'b0;
        push(8'h04, 4'd0);
        push(8'hE0, 4'd1);
        push(8'h13, 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_pc0", {28'b0, pc}, 0);
        wait_done(20);
        check("done_cnt5", done_cnt, 5);
        check("q_empty5", exp_q.size(), 0);

        // Reset mid-run, start on empty buffer, clear beats load
        inst_rdy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrun_vld", {31'b0, inst_vld}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state();
        inst_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start_busy", {31'b0, busy}, 0);
        check("empty_start_vld", {31'b0, inst_vld}, 0);
        load_word(8'h11);
        check("reload_count", {27'b0, count}, 1);
        load_vld  = 1'b1;
        clear     = 1'b1;
        load_data = 8'h22;
        tick();
        load_vld = 1'b0;
        clear    = 1'b0;
        check("clear_beats_load", {27'b0, count}, 0);
        check("q_empty_end", exp_q.size(), 0);
        check("done_cnt_end", done_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
